inv_for_1543: RTL
=================

Name: inv_for_1543

Overview:
- Sequential modular inverter over GF(1543): returns a^-1 mod 1543 by Fermat exponentiation, a^(1543-2) = a^1541, using left-to-right square-and-multiply.
- Inverse-direction companion to the combinational Barrett reducer family. It sits after reduction stages wherever a division by a field element is needed.
- It has one internal single-cycle modular multiplier with exact reduction and a valid/ready handshake on both sides.

Parameters:
- Q, 1543: prime modulus.
- W, 11: operand and result width, ceil(log2 Q).
- EXP, 1541: exponent Q-2 = 11'b11000000101.
- Only the defaults are verified. Any other Q must be prime, and must satisfy W = ceil(log2 Q) and EXP = Q-2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand offered
- in_ready  output  1  block can accept an operand
- din_a  input  11  operand, 0..2047
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- dout_r  output  11  a^-1 mod 1543, range 0..1542

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, dout_r=0, acc=1, bit index=10.
- Reset mid-operation: the block returns to IDLE on the next edge. The partial result is discarded and no out_valid pulse is produced.
- States: IDLE, SQR, MUL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch a = (din_a >= 1543) ? din_a-1543 : din_a; set acc=1, idx=10; go to SQR.
- SQR:
  - acc <= acc*acc mod Q.
  - If EXP[idx]=1, go to MUL.
  - Else if idx==0, go to DONE.
  - Else idx <= idx-1 and stay in SQR.
- MUL:
  - acc <= acc*a mod Q.
  - If idx==0, go to DONE.
  - Else idx <= idx-1 and go to SQR.
- DONE:
  - out_valid=1 and dout_r=acc.
  - dout_r is held stable while out_ready=0.
  - On out_ready: go to IDLE. out_valid drops on that edge.
- Latency:
  - Fixed and data-independent: 11 SQR + 4 MUL = 15 busy cycles.
  - out_valid rises 16 edges after the accepting edge: the accepting edge plus 15 busy edges.
  - Throughput is one result per 17 cycles minimum. There is no input/output overlap: in_ready=0 in SQR, MUL and DONE.
- Arithmetic:
  - Products are up to 1542^2 = 2377764, which needs 22 bits. The internal reducer must be 22-bit wide and exact: output in 0..1542 for every product.
  - A Barrett estimate plus the required conditional subtractions is acceptable; a truncating 21-bit datapath is not.
  - The reducer is combinational within one cycle. There is no multicycle path.
- Boundary conditions:
  - a=0 yields 0; the block flags nothing.
  - din_a in 1543..2047 is pre-reduced once.
  - in_valid asserted outside IDLE is ignored, with no side effects.
  - din_a is sampled only on the accepting edge; later changes have no effect.
- out_valid and dout_r are registered outputs. in_ready is decoded from the state register.

Test Plan:
- Reset, then in_valid with din_a=2 -> out_valid exactly 16 edges after acceptance, dout_r=772; in_ready=0 throughout.
- Inputs 1, 3, 1542 back-to-back with out_ready=1 -> results 1, 1029, 1542; each new accept happens no earlier than one cycle after the previous out handshake.
- din_a=0 -> 0. din_a=1544 -> 1 (pre-reduced). din_a=2047 (reduces to 504) -> r with 504*r mod 1543 = 1.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_valid and dout_r stable; a concurrent in_valid is ignored; release -> one handshake, then IDLE.
- Assert rst at busy cycle 7 -> next cycle IDLE, in_ready=1, out_valid=0; a fresh operand 5 -> 926 (5*926 = 4630 = 3*1543+1).
- Exhaustive sweep 1..1542 with a reference model -> din*dout mod 1543 == 1 for all, latency constant at 16.

Source files
------------

// File: rtl/inv_for_1543.sv
// Modular inverter over GF(Q), default Q = 1543.
// Computes a^-1 = a^(Q-2) mod Q by left-to-right square-and-multiply.
// The sequence is fixed and does not depend on the data: one square per
// exponent bit, and a multiply after each square whose bit is set.
// Operands in Q..2^W-1 are reduced once on acceptance.
// a = 0 produces 0 and raises no flag.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | in_ready high, waiting for an operand
//   SQR   | acc <= acc*acc mod Q for exponent bit idx
//   MUL   | acc <= acc*a mod Q, taken when exponent bit idx is set
//   DONE  | out_valid high, dout_r held until out_ready
module inv_for_1543 #(
    parameter int Q   = 1543,
    parameter int W   = 11,
    parameter int EXP = 1541
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] din_a,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] dout_r
);

    localparam int PW   = 2 * W;            // product width
    localparam int BK   = PW + 2;           // Barrett shift
    localparam int MW   = BK - W + 1;       // Barrett constant width
    localparam int IDXW = $clog2(W);
    localparam longint BM = (longint'(1) << BK) / longint'(Q);

    localparam logic [W-1:0]    Q_W    = W'(Q);
    localparam logic [PW-1:0]   Q_P    = PW'(Q);
    localparam logic [MW-1:0]   BM_V   = MW'(BM);
    localparam logic [W-1:0]    EXP_V  = W'(EXP);
    localparam logic [IDXW-1:0] IDX_HI = IDXW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SQR  = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_acc;
    logic [IDXW-1:0]   r_idx;
    logic              r_out_valid;
    logic [W-1:0]      r_dout;

    logic [W-1:0]      w_a_in;
    logic              w_exp_bit;
    logic [W-1:0]      w_mul_b;
    logic [PW-1:0]     w_prod;
    logic [PW+MW-1:0]  w_qprod;
    logic [PW-W:0]     w_qest;
    logic [PW-1:0]     w_qq;
    logic [PW-1:0]     w_r0;
    logic [PW-1:0]     w_r1;
    logic [W-1:0]      w_red;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign dout_r    = r_dout;

    // Single pre-reduction brings 0..2^W-1 into 0..Q-1.
    assign w_a_in    = (din_a >= Q_W) ? (din_a - Q_W) : din_a;
    assign w_exp_bit = EXP_V[r_idx];

    // One shared multiplier: squares acc in SQR, multiplies by a in MUL.
    always_comb begin
        w_mul_b = (r_state == S_MUL) ? r_a : r_acc;
        w_prod  = {{W{1'b0}}, r_acc} * {{W{1'b0}}, w_mul_b};
    end

    // Exact Barrett reduction of the full 2W-bit product. The quotient
    // estimate is at most one short, so the first subtraction already
    // lands in range; the second keeps the result exact under any
    // rounding of the estimate.
    always_comb begin
        w_qprod = {{MW{1'b0}}, w_prod} * {{PW{1'b0}}, BM_V};
        w_qest  = w_qprod[PW+MW-1:BK];
        w_qq    = {{(W-1){1'b0}}, w_qest} * Q_P;
        w_r0    = w_prod - w_qq;
        w_r1    = (w_r0 >= Q_P) ? (w_r0 - Q_P) : w_r0;
        w_red   = (w_r1 >= Q_P) ? W'(w_r1 - Q_P) : W'(w_r1);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode. in_valid is only looked at in IDLE, so an offer
    // made while busy or holding a result has no effect.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = S_SQR;
                end
            end
            S_SQR: begin
                if (w_exp_bit) begin
                    w_state_nxt = S_MUL;
                end else if (r_idx == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_MUL: begin
                if (r_idx == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_SQR;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered outputs. The result is captured on the edge
    // that enters DONE, so out_valid and dout_r rise together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a         <= '0;
            r_acc       <= W'(1);
            r_idx       <= IDX_HI;
            r_out_valid <= 1'b0;
            r_dout      <= '0;
        end else begin
            r_out_valid <= (w_state_nxt == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a   <= w_a_in;
                        r_acc <= W'(1);
                        r_idx <= IDX_HI;
                    end
                end
                S_SQR: begin
                    r_acc <= w_red;
                    if (!w_exp_bit && (r_idx != '0)) begin
                        r_idx <= r_idx - 1'b1;
                    end
                    if (w_state_nxt == S_DONE) begin
                        r_dout <= w_red;
                    end
                end
                S_MUL: begin
                    r_acc <= w_red;
                    if (r_idx != '0) begin
                        r_idx <= r_idx - 1'b1;
                    end
                    if (w_state_nxt == S_DONE) begin
                        r_dout <= w_red;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
